// File: rtl/boot_rom_copier_pkg.sv
// Shared types and constants for the boot ROM to SRAM copier.
package boot_rom_copier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned STRB_W     = DATA_W_DEF / 8;
  localparam logic [STRB_W-1:0] STRB_ALL = {STRB_W{1'b1}};

  // A single-word image still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/boot_csum_acc.sv
// Running modulo-2^DATA_W sum of accepted words; clear wins over enable.
module boot_csum_acc
  import boot_rom_copier_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i)     sum_d = '0;
    else if (en_i) sum_d = sum_q + data_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)  sum_q <= '0;
    else if (cke_i) sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/boot_rom_copier.sv
// Copies the bootloader image from ROM to SRAM and holds the CPU in reset meanwhile.
// Optional checksum output enabled by defining BOOT_CHECKSUM_EN.
module boot_rom_copier
  import boot_rom_copier_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = DATA_W_DEF,
  parameter int unsigned       ROM_ADDR_W = 10,
  parameter int unsigned       BOOT_WORDS = 512,
  parameter logic [ADDR_W-1:0] SRAM_BASE  = '0
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  boot_i,
  input  logic                  cpu_reset_i,
  output logic                  rom_en_o,
  output logic [ROM_ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0]     rom_rdata_i,
  output logic                  iob_avalid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_ready_i,
  output logic                  cpu_rst_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef BOOT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     checksum_o
`endif
);

  localparam int unsigned CNT_W = cnt_width(BOOT_WORDS);
  localparam int unsigned SW    = DATA_W / 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BOOT_WORDS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              rst_prev_q, rst_prev_d;

  logic start;
  logic abort;

  // The start term keeps cpu_rst_o high in the edge cycle, before busy_o rises.
  assign start = rst_prev_q & ~cpu_reset_i & boot_i & (state_q == ST_IDLE);
  assign abort = cpu_reset_i & busy_o;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      rst_prev_q <= 1'b0;
    end else if (cke_i) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      rst_prev_q <= rst_prev_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    rst_prev_d = cpu_reset_i;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RD;
            cnt_d   = '0;
            done_d  = 1'b0;
          end
        end
        ST_RD:  state_d = ST_CAP;
        ST_CAP: begin
          wdata_d = rom_rdata_i;
          state_d = ST_WR;
        end
        ST_WR: begin
          if (iob_ready_i) begin
            if (cnt_q == LAST_IDX) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = ST_RD;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rom_en_o     = (state_q == ST_RD);
    iob_avalid_o = (state_q == ST_WR);
    iob_wstrb_o  = (state_q == ST_WR) ? {SW{1'b1}} : '0;
    busy_o       = (state_q != ST_IDLE);
  end

  assign rom_addr_o  = ROM_ADDR_W'(cnt_q);
  assign iob_addr_o  = SRAM_BASE + ADDR_W'(cnt_q) * ADDR_W'(SW);
  assign iob_wdata_o = wdata_q;
  assign done_o      = done_q;
  assign cpu_rst_o   = cpu_reset_i | busy_o | start;

`ifdef BOOT_CHECKSUM_EN
  logic wr_ack;
  assign wr_ack = iob_avalid_o & iob_ready_i;

  boot_csum_acc #(
    .DATA_W(DATA_W)
  ) u_csum (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .cke_i   (cke_i),
    .clr_i   (start | abort),
    .en_i    (wr_ack),
    .data_i  (wdata_q),
    .sum_o   (checksum_o)
  );
`endif

endmodule

// File: tb/tb_boot_rom_copier.sv
// Self-checking bench for boot_rom_copier: 4-word image, SRAM at 0x1000, stallable SRAM model.
module tb_boot_rom_copier;
  import boot_rom_copier_pkg::*;

  localparam int NW = 4;
  localparam logic [31:0] BASE = 32'h1000;

  logic        clk = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        cke_i = 1'b1;
  logic        boot_i = 1'b0;
  logic        cpu_reset_i = 1'b1;
  logic        rom_en_o;
  logic [9:0]  rom_addr_o;
  logic [31:0] rom_rdata_i = '0;
  logic        iob_avalid_o;
  logic [31:0] iob_addr_o;
  logic [31:0] iob_wdata_o;
  logic [3:0]  iob_wstrb_o;
  logic        iob_ready_i = 1'b0;
  logic        cpu_rst_o;
  logic        busy_o;
  logic        done_o;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] checksum_o;
`endif

  boot_rom_copier #(
    .ADDR_W(32), .DATA_W(32), .ROM_ADDR_W(10), .BOOT_WORDS(NW), .SRAM_BASE(BASE)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n_i), .cke_i(cke_i), .boot_i(boot_i),
    .cpu_reset_i(cpu_reset_i), .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o),
    .rom_rdata_i(rom_rdata_i), .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o),
    .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i),
    .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o)
`ifdef BOOT_CHECKSUM_EN
    , .checksum_o(checksum_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ROM: one-cycle registered read
  logic [31:0] rom_mem [0:NW-1];
  always @(posedge clk) if (rom_en_o) rom_rdata_i <= rom_mem[rom_addr_o[1:0]];

  // SRAM side: per-word stall counts, handshake log, hold/strobe rules
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
  wr_t         wr_q[$];
  logic [31:0] stall_cfg = '0;
  bit          req_active = 0, hold_pending = 0;
  int          stall_left = 0;
  logic [31:0] held_addr, held_data;

  always @(posedge clk)
    if (arst_n_i && iob_avalid_o && iob_ready_i)
      wr_q.push_back('{addr: iob_addr_o, data: iob_wdata_o, strb: iob_wstrb_o});

  always @(negedge clk) begin
    if (!arst_n_i) begin
      iob_ready_i = 0; req_active = 0; hold_pending = 0;
    end else if (iob_avalid_o) begin
      chk("wstrb_on", iob_wstrb_o, STRB_ALL);
      if (hold_pending) begin
        chk("hold_addr", iob_addr_o, held_addr);
        chk("hold_data", iob_wdata_o, held_data);
      end
      if (!req_active) begin
        logic [31:0] idx;
        idx = (iob_addr_o - BASE) >> 2;
        req_active = 1;
        stall_left = int'(stall_cfg[8*idx[1:0] +: 8]);
      end
      if (stall_left > 0) begin iob_ready_i = 0; stall_left--; end
      else begin iob_ready_i = 1; req_active = 0; end
      hold_pending = !iob_ready_i;
      held_addr = iob_addr_o;
      held_data = iob_wdata_o;
    end else begin
      chk("wstrb_off", iob_wstrb_o, '0);
      iob_ready_i = 0; req_active = 0; hold_pending = 0;
    end
  end

  // Reference expectations
  bit          done_model = 0;
  logic [31:0] csum_model = '0;

  function automatic logic [31:0] rom_sum();
    logic [31:0] s = '0;
    for (int i = 0; i < NW; i++) s += rom_mem[i];
    return s;
  endfunction

  task automatic check_copy(input string tag, input int n_exp);
    chk({tag, "_nwr"}, wr_q.size(), n_exp);
    for (int i = 0; i < wr_q.size() && i < n_exp; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, BASE + 32'(4 * i));
      chk($sformatf("%s_data%0d", tag, i), wr_q[i].data, rom_mem[i]);
      chk($sformatf("%s_strb%0d", tag, i), wr_q[i].strb, STRB_ALL);
    end
    wr_q.delete();
  endtask

  // Drive a pulse, release it, count cycles cpu_rst_o stays high afterwards.
  task automatic do_pulse(input bit b, input int len, output int high);
    @(posedge clk); #1;
    boot_i = b;
    cpu_reset_i = 1;
    repeat (len) @(posedge clk);
    @(negedge clk);
    chk("rst_during_pulse", cpu_rst_o, 1'b1);
    @(posedge clk); #1;
    cpu_reset_i = 0;
    high = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!cpu_rst_o) break;
      high++;
    end
    if (high >= 300) begin
      errors++;
      $display("FAIL timeout cpu_rst_o actual=1 required=0");
    end
  endtask

  task automatic run_and_check(input string tag, input bit b, input int len,
                               input logic [31:0] stalls, input int exp_high,
                               input bit exp_done, input int exp_nwr);
    int high;
    stall_cfg = stalls;
    do_pulse(b, len, high);
    $display("run %s boot=%0d pulse=%0d stalls=%08h high_after=%0d writes=%0d done=%0d",
             tag, b, len, stalls, high, wr_q.size(), done_o);
    chk({tag, "_high"}, high, exp_high);
    chk({tag, "_done"}, done_o, exp_done);
    chk({tag, "_busy"}, busy_o, 1'b0);
    check_copy(tag, exp_nwr);
`ifdef BOOT_CHECKSUM_EN
    chk({tag, "_csum"}, checksum_o, csum_model);
`endif
  endtask

  task automatic wait_writes(input int n);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (wr_q.size() >= n) return;
    end
    errors++;
    $display("FAIL timeout writes actual=%0d required=%0d", wr_q.size(), n);
  endtask

  typedef struct {
    bit          boot;
    int          pulse;
    logic [31:0] stalls;  // byte i = wait cycles on word i
    int          exp_high; // cycles after release: start cycle + 3 per word + stalls
    bit          exp_done;
    int          exp_nwr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int high;
    vecs[0] = '{boot: 0, pulse: 10,  stalls: 32'h0,        exp_high: 0,  exp_done: 0, exp_nwr: 0};
    vecs[1] = '{boot: 1, pulse: 100, stalls: 32'h0,        exp_high: 13, exp_done: 1, exp_nwr: 4};
    vecs[2] = '{boot: 1, pulse: 3,   stalls: 32'h00000500, exp_high: 18, exp_done: 1, exp_nwr: 4};
    vecs[3] = '{boot: 0, pulse: 7,   stalls: 32'h0,        exp_high: 0,  exp_done: 1, exp_nwr: 0};
    vecs[4] = '{boot: 1, pulse: 1,   stalls: 32'h01010101, exp_high: 17, exp_done: 1, exp_nwr: 4};
    rom_mem[0] = 32'h11; rom_mem[1] = 32'h22; rom_mem[2] = 32'h33; rom_mem[3] = 32'h44;

    // Reset values, cpu_rst_o follows cpu_reset_i while in reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rom_en", rom_en_o, 1'b0);
    chk("rst_rom_addr", rom_addr_o, '0);
    chk("rst_avalid", iob_avalid_o, 1'b0);
    chk("rst_addr", iob_addr_o, BASE);
    chk("rst_wdata", iob_wdata_o, '0);
    chk("rst_wstrb", iob_wstrb_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_cpu_hi", cpu_rst_o, 1'b1);
`ifdef BOOT_CHECKSUM_EN
    chk("rst_csum", checksum_o, '0);
`endif
    cpu_reset_i = 0;
    #1;
    chk("rst_cpu_lo", cpu_rst_o, 1'b0);
    @(posedge clk); #1;
    arst_n_i = 1;

    // Table vectors
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].boot) csum_model = rom_sum();
      run_and_check($sformatf("vec%0d", v), vecs[v].boot, vecs[v].pulse, vecs[v].stalls,
                    vecs[v].exp_high, vecs[v].exp_done, vecs[v].exp_nwr);
    end
    done_model = 1;

    // Abort during word 3, then a clean restart from word 0
    stall_cfg = '0;
    @(posedge clk); #1; boot_i = 1; cpu_reset_i = 1;
    @(posedge clk); #1; cpu_reset_i = 0;
    wait_writes(2);
    cpu_reset_i = 1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_done", done_o, 1'b0);
    chk("abort_avalid", iob_avalid_o, 1'b0);
    chk("abort_addr", iob_addr_o, BASE);
    chk("abort_cpu_rst", cpu_rst_o, 1'b1);
`ifdef BOOT_CHECKSUM_EN
    chk("abort_csum", checksum_o, '0);
`endif
    $display("run abort writes_before=%0d", wr_q.size());
    chk("abort_nwr", wr_q.size(), 2);
    wr_q.delete();
    csum_model = rom_sum();
    run_and_check("restart", 1, 5, 32'h0, 13, 1, 4);

    // Asynchronous reset mid-copy
    @(posedge clk); #1; boot_i = 1; cpu_reset_i = 1;
    @(posedge clk); #1; cpu_reset_i = 0;
    wait_writes(1);
    arst_n_i = 0;
    #1;
    chk("arst_rom_en", rom_en_o, 1'b0);
    chk("arst_rom_addr", rom_addr_o, '0);
    chk("arst_avalid", iob_avalid_o, 1'b0);
    chk("arst_addr", iob_addr_o, BASE);
    chk("arst_wdata", iob_wdata_o, '0);
    chk("arst_wstrb", iob_wstrb_o, '0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_done", done_o, 1'b0);
    chk("arst_cpu_rst", cpu_rst_o, 1'b0);
`ifdef BOOT_CHECKSUM_EN
    chk("arst_csum", checksum_o, '0);
`endif
    repeat (3) @(posedge clk);
    #1; arst_n_i = 1;
    repeat (20) @(posedge clk);
    #1;
    $display("run arst writes=%0d done=%0d", wr_q.size(), done_o);
    chk("arst_nwr", wr_q.size(), 1);
    chk("arst_done_after", done_o, 1'b0);
    wr_q.delete();
    done_model = 0;
    csum_model = '0;

    // Randomized runs against the reference expectations
    for (int r = 0; r < 10; r++) begin
      bit          b;
      int          len, exp_high;
      logic [31:0] st;
      b   = ($urandom % 4) != 0;
      len = $urandom_range(1, 20);
      st  = '0;
      exp_high = 0;
      for (int i = 0; i < NW; i++) begin
        int s = $urandom_range(0, 3);
        st[8*i +: 8] = 8'(s);
        exp_high += s;
        rom_mem[i] = $urandom;
      end
      if (b) begin
        exp_high += 3 * NW + 1;
        done_model = 1;
        csum_model = rom_sum();
      end else begin
        exp_high = 0;
      end
      run_and_check($sformatf("rnd%0d", r), b, len, st, exp_high, done_model, b ? NW : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
